// File: rtl/pixel_pkg.sv
// Shared raster geometry defaults and FSM state type for the 1-bit frame writer.
// Optional missing-pixel detection is enabled with FRAME_GAP_DETECT_EN.
package pixel_pkg;

    localparam int H_ACTIVE_DEF    = 320;
    localparam int V_ACTIVE_DEF    = 240;
    localparam int WORD_W_DEF      = 16;
    localparam int WORDS_PER_LINE  = H_ACTIVE_DEF / WORD_W_DEF;
    localparam int WORDS_PER_FRAME = WORDS_PER_LINE * V_ACTIVE_DEF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        CAPTURE  = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/bit_packer.sv
// Packs accepted 1-bit pixels into WORD_W-wide words and flags words ready to write.
// With FRAME_GAP_DETECT_EN a per-word valid mask drives gap events and abandoned-word flushes.
module bit_packer
    import pixel_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int ADDR_W = 8,
    localparam int BIT_W = $clog2(WORD_W)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              clear_in,
    input  logic              accept_in,
    input  logic              pixel_in,
    input  logic [BIT_W-1:0]  bit_idx_in,
    input  logic [ADDR_W-1:0] word_idx_in,
    output logic              emit_out,
    output logic [WORD_W-1:0] emit_data_out,
    output logic [ADDR_W-1:0] emit_idx_out,
    output logic              gap_evt_out
);

    logic [WORD_W-1:0] acc_q, acc_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [WORD_W-1:0] work_acc;
    logic              mismatch;
`ifdef FRAME_GAP_DETECT_EN
    logic [WORD_W-1:0] mask_q, mask_d;
    logic [WORD_W-1:0] work_mask;
`endif

    always_comb begin
        acc_d         = acc_q;
        pend_d        = pend_q;
        idx_d         = idx_q;
        emit_out      = 1'b0;
        emit_data_out = '0;
        emit_idx_out  = idx_q;
        gap_evt_out   = 1'b0;
        work_acc      = '0;
        mismatch      = 1'b0;
`ifdef FRAME_GAP_DETECT_EN
        mask_d        = mask_q;
        work_mask     = '0;
`endif
        if (clear_in) begin
            acc_d  = '0;
            pend_d = 1'b0;
`ifdef FRAME_GAP_DETECT_EN
            mask_d = '0;
`endif
        end else if (accept_in) begin
            // A pixel from a different word abandons whatever partial word is pending
            mismatch             = pend_q && (word_idx_in != idx_q);
            work_acc             = mismatch ? '0 : acc_q;
            work_acc[bit_idx_in] = pixel_in;
`ifdef FRAME_GAP_DETECT_EN
            work_mask             = mismatch ? '0 : mask_q;
            work_mask[bit_idx_in] = 1'b1;
`endif
            if (int'(bit_idx_in) == WORD_W - 1) begin
                emit_out      = 1'b1;
                emit_data_out = work_acc;
                emit_idx_out  = word_idx_in;
                acc_d         = '0;
                pend_d        = 1'b0;
`ifdef FRAME_GAP_DETECT_EN
                mask_d        = '0;
                gap_evt_out   = mismatch || !(&work_mask);
`endif
            end else begin
                acc_d  = work_acc;
                pend_d = 1'b1;
                idx_d  = word_idx_in;
`ifdef FRAME_GAP_DETECT_EN
                mask_d = work_mask;
                if (mismatch) begin
                    emit_out      = 1'b1;
                    emit_data_out = acc_q;
                    emit_idx_out  = idx_q;
                    gap_evt_out   = 1'b1;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            acc_q  <= '0;
            pend_q <= 1'b0;
            idx_q  <= '0;
`ifdef FRAME_GAP_DETECT_EN
            mask_q <= '0;
`endif
        end else begin
            acc_q  <= acc_d;
            pend_q <= pend_d;
            idx_q  <= idx_d;
`ifdef FRAME_GAP_DETECT_EN
            mask_q <= mask_d;
`endif
        end
    end

endmodule

// File: rtl/frame_bit_writer.sv
// Captures one frame of 1-bit pixels into packed BRAM words: FSM, pixel gating and addressing.
// Define FRAME_GAP_DETECT_EN to enable sticky missing-pixel reporting on gap_out.
module frame_bit_writer
    import pixel_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int WORD_W   = WORD_W_DEF,
    localparam int WPL     = H_ACTIVE / WORD_W,
    localparam int WPF     = WPL * V_ACTIVE,
    localparam int ADDR_W  = $clog2(WPF),
    localparam int BIT_W   = $clog2(WORD_W)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    input  logic              data_valid_in,
    input  logic              pixel_data_in,
    input  logic [10:0]       hcount_in,
    input  logic [9:0]        vcount_in,
    output logic [ADDR_W-1:0] bram_addr_out,
    output logic [WORD_W-1:0] bram_data_out,
    output logic              bram_we_out,
    output logic              busy_out,
    output logic              frame_done_out,
    output logic              gap_out
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WPF - 1);

    fsm_state_t        state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              gap_q, gap_d;

    logic              in_range;
    logic              accept;
    logic [ADDR_W-1:0] word_idx;
    logic [BIT_W-1:0]  bit_idx;
    logic              emit;
    logic [WORD_W-1:0] emit_data;
    logic [ADDR_W-1:0] emit_idx;
    logic              gap_evt;

    assign in_range = (int'(hcount_in) < H_ACTIVE) && (int'(vcount_in) < V_ACTIVE);
    // Only the (0,0) pixel may be taken while waiting for start of frame
    assign accept   = data_valid_in && in_range &&
                      ((state_q == CAPTURE) ||
                       (state_q == WAIT_SOF && hcount_in == '0 && vcount_in == '0));
    assign word_idx = ADDR_W'(int'(vcount_in) * WPL + int'(hcount_in) / WORD_W);
    assign bit_idx  = BIT_W'(int'(hcount_in) % WORD_W);

    bit_packer #(
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W)
    ) u_packer (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .clear_in      (state_q == IDLE),
        .accept_in     (accept),
        .pixel_in      (pixel_data_in),
        .bit_idx_in    (bit_idx),
        .word_idx_in   (word_idx),
        .emit_out      (emit),
        .emit_data_out (emit_data),
        .emit_idx_out  (emit_idx),
        .gap_evt_out   (gap_evt)
    );

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        we_d    = emit;
        addr_d  = emit ? emit_idx : addr_q;
        data_d  = emit ? emit_data : data_q;
        done_d  = emit && (emit_idx == LAST_IDX) && (state_q == CAPTURE);
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    state_d = WAIT_SOF;
                    gap_d   = 1'b0;
                end
            end
            WAIT_SOF: begin
                if (accept) state_d = CAPTURE;
            end
            CAPTURE: begin
                // done_q marks the cycle the final word is on the bus
                if (done_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (gap_evt) gap_d = 1'b1;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            gap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            gap_q   <= gap_d;
        end
    end

    assign bram_addr_out  = addr_q;
    assign bram_data_out  = data_q;
    assign bram_we_out    = we_q;
    assign busy_out       = busy_q;
    assign frame_done_out = done_q;
`ifdef FRAME_GAP_DETECT_EN
    assign gap_out        = gap_q;
`else
    assign gap_out        = 1'b0;
`endif

endmodule

// File: doc/frame_bit_writer.md
FRAME_BIT_WRITER -- requirements
Module: frame_bit_writer

Interface
REQ-001: Parameter H_ACTIVE, default 320, active pixels per line; SHALL be a multiple of WORD_W.
REQ-002: Parameter V_ACTIVE, default 240, active lines per frame.
REQ-003: Parameter WORD_W, default 16, pixels packed per memory word.
REQ-004: clk_in  input  1  single clock; all logic SHALL be on its rising edge.
REQ-005: rst_in  input  1  reset, asynchronous, active-high.
REQ-006: start_in  input  1  one-cycle pulse arming a single-frame capture.
REQ-007: data_valid_in  input  1  pixel qualifier from the 1-bit pixel pipeline.
REQ-008: pixel_data_in  input  1  binary pixel.
REQ-009: hcount_in  input  11  pixel column; vcount_in  input  10  pixel row.
REQ-010: bram_addr_out  output  $clog2(H_ACTIVE*V_ACTIVE/WORD_W)  word address.
REQ-011: bram_data_out  output  WORD_W  packed word; bram_we_out  output  1  write strobe.
REQ-012: busy_out  output  1  high from arm until frame completion.
REQ-013: frame_done_out  output  1  one-cycle pulse on final word write.
REQ-014: gap_out  output  1  sticky missing-pixel flag.

Function
REQ-015: FSM states IDLE, WAIT_SOF, CAPTURE; IDLE->WAIT_SOF on start_in; WAIT_SOF->CAPTURE on valid pixel with hcount_in=0, vcount_in=0; CAPTURE->IDLE after final word write.
REQ-016: start_in outside IDLE SHALL be ignored.
REQ-017: Pixels SHALL be accepted only in WAIT_SOF (the SOF pixel itself) and CAPTURE with data_valid_in=1, hcount_in<H_ACTIVE, vcount_in<V_ACTIVE; others ignored.
REQ-018: Accepted pixel SHALL land at bit hcount_in mod WORD_W of the accumulating word; bit 0 = leftmost pixel.
REQ-019: Word index SHALL be vcount_in*(H_ACTIVE/WORD_W) + hcount_in/WORD_W.
REQ-020: When the accepted pixel has hcount_in mod WORD_W = WORD_W-1, bram_we_out SHALL pulse for one cycle on the next cycle with that word and its index; latency exactly 1 cycle.
REQ-021: Unwritten bit positions in an emitted word SHALL be 0; accumulator SHALL clear after each write.
REQ-022: Write of word index H_ACTIVE*V_ACTIVE/WORD_W-1 SHALL coincide with frame_done_out=1 and busy_out falling next cycle.
REQ-023: bram_addr_out/bram_data_out SHALL hold last written values when bram_we_out=0.
REQ-024: Back-to-back words SHALL be written on consecutive write cycles without loss; no backpressure exists.

Reset
REQ-025: rst_in SHALL asynchronously force state IDLE, accumulator 0, bram_we_out 0, bram_addr_out 0, bram_data_out 0, busy_out 0, frame_done_out 0, gap_out 0.
REQ-026: Reset mid-capture SHALL discard the partial word with no write issued.

Configuration
REQ-027: Macro FRAME_GAP_DETECT_EN defined: per-word valid mask SHALL be kept; a word emitted with an incomplete mask, or an accepted pixel whose word index differs from the pending partial word, SHALL set gap_out; the abandoned partial word SHALL be written (missing bits 0) one cycle after the mismatch; gap_out SHALL clear on accepted start_in.
REQ-028: Macro undefined: gap_out SHALL be constant 0, no mask, abandoned partial words silently dropped.

Structure
REQ-029: Package pixel_pkg SHALL hold H_ACTIVE/V_ACTIVE/WORD_W defaults, derived WORDS_PER_LINE/WORDS_PER_FRAME and the FSM state enum.
REQ-030: Sub-module bit_packer SHALL own the accumulator, mask and word-complete detection; frame_bit_writer owns FSM and addressing.

Verification
REQ-031: Reset, start_in, raster of alternating 1/0 pixels -> 4800 writes, addr 0..4799 in order, every data 16'h5555, one frame_done_out on addr 4799.
REQ-032: Pixels streamed before start_in, then start_in mid-frame -> no writes until next (0,0) pixel; first write addr 0.
REQ-033: Pixel at hcount 15 vcount 0 value 1 -> next cycle bram_we_out=1, addr 0, data bit 15 set.
REQ-034: FRAME_GAP_DETECT_EN, drop pixel (5,2) -> word 40 written with bit 5=0, gap_out=1 until next start_in.
REQ-035: rst_in asserted after 100 captured pixels -> outputs zero immediately, no further writes, busy_out 0.
REQ-036: hcount_in=330 valid pixels and start_in during CAPTURE -> ignored, write sequence unchanged.
